// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encodings for the instruction fetch stage.
package fetch_unit_pkg;

   localparam logic [15:0] NOP_WORD_DEF = 16'h0000;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   typedef enum logic [0:0] {
      FS_RUN   = 1'b0,
      FS_FLUSH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/grant and in-order response bus.
interface fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input imem_gnt, input imem_rvalid, input imem_rdata);
   modport slave  (input imem_req, input imem_addr,
                   output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch FIFO holding {pc, word} pairs; clear empties it in one cycle.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_s,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   // Pointer and occupancy tracking; clear wins over push/pop.
   always_ff @(posedge clk) begin
      if (rst_s || clr) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
         if (push && !pop)      count_r <= count_r + CW'(1);
         else if (pop && !push) count_r <= count_r - CW'(1);
         else                   count_r <= count_r;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (rst_s) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else if (push) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == CW'(0));
   assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word reads and feeds the decoder from a prefetch queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2,
   parameter logic [15:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic                clk,
   input  logic                rst_s,
   fetch_unit_if.master        imem,
   input  logic                redirect_val,
   input  logic [15:0]         redirect_pc,
   input  logic                stall,
   input  logic                hold_pc,
   output logic [15:0]         q,
   output logic                q_valid,
   output logic [15:0]         q_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_r, state_nxt_s;
   logic [15:0]   fetch_pc_r, resp_pc_r;
   logic [CW-1:0] outstanding_r, outstanding_nxt_s;
   logic [CW-1:0] discard_r, discard_nxt_s;
   logic          hold_seen_r;
   logic [CW-1:0] occ_s;
   logic          q_empty_s, q_full_s;
   logic [31:0]   head_s;
   logic          credit_s, req_s, grant_s, rvalid_s, push_s, pop_s, q_valid_s;

   // Credit counts both buffered words and words still in flight.
   assign credit_s  = ({1'b0, occ_s} + {1'b0, outstanding_r}) < (CW + 1)'(DEPTH);
   assign req_s     = ~rst_s & ~redirect_val & credit_s;
   assign grant_s   = req_s & imem.imem_gnt;
   assign rvalid_s  = imem.imem_rvalid & (outstanding_r != CW'(0));
   assign q_valid_s = ~q_empty_s & (state_r == FS_RUN);
   assign push_s    = rvalid_s & ~redirect_val & (discard_r == CW'(0)) & (state_r == FS_RUN)
                    & (~q_full_s | pop_s);
   assign pop_s     = q_valid_s & ~stall & ~(hold_pc & ~hold_seen_r) & ~redirect_val;

   assign imem.imem_req  = req_s;
   assign imem.imem_addr = fetch_pc_r;

   // In-flight and to-be-dropped response accounting.
   always_comb begin
      outstanding_nxt_s = outstanding_r;
      discard_nxt_s     = discard_r;
      if (grant_s && !rvalid_s)      outstanding_nxt_s = outstanding_r + CW'(1);
      else if (!grant_s && rvalid_s) outstanding_nxt_s = outstanding_r - CW'(1);
      else                           outstanding_nxt_s = outstanding_r;
      if (redirect_val)                            discard_nxt_s = outstanding_r - (rvalid_s ? CW'(1) : CW'(0));
      else if (rvalid_s && discard_r != CW'(0))   discard_nxt_s = discard_r - CW'(1);
      else                                         discard_nxt_s = discard_r;
   end

   // Flush state next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FS_RUN:   state_nxt_s = (redirect_val && discard_nxt_s != CW'(0)) ? FS_FLUSH : FS_RUN;
         FS_FLUSH: state_nxt_s = (discard_nxt_s == CW'(0)) ? FS_RUN : FS_FLUSH;
         default:  state_nxt_s = FS_RUN;
      endcase
   end

   // Flush state register.
   always_ff @(posedge clk) begin
      if (rst_s) state_r <= FS_RUN;
      else       state_r <= state_nxt_s;
   end

   // PC, response tag, counters and decoder hold tracking.
   always_ff @(posedge clk) begin
      if (rst_s) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= CW'(0);
         discard_r     <= CW'(0);
         hold_seen_r   <= 1'b0;
      end else begin
         if (redirect_val) begin
            fetch_pc_r <= redirect_pc;
            resp_pc_r  <= redirect_pc;
         end else begin
            if (grant_s) fetch_pc_r <= fetch_pc_r + 16'd1;
            if (push_s)  resp_pc_r  <= resp_pc_r + 16'd1;
         end
         outstanding_r <= outstanding_nxt_s;
         discard_r     <= discard_nxt_s;
         hold_seen_r   <= hold_pc & q_valid_s & ~hold_seen_r & ~stall & ~redirect_val;
      end
   end

   fetch_queue #(.DEPTH(DEPTH), .WIDTH(32)) u_queue (
      .clk   (clk),
      .rst_s (rst_s),
      .clr   (redirect_val),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({resp_pc_r, imem.imem_rdata}),
      .rdata (head_s),
      .full  (q_full_s),
      .empty (q_empty_s),
      .count (occ_s)
   );

   // Decoder-facing view of the queue head.
   always_comb begin
      q_valid = q_valid_s;
      if (q_valid_s) begin
         q    = head_s[15:0];
         q_pc = head_s[31:16];
      end else begin
         q    = NOP_WORD;
         q_pc = 16'h0000;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Owns the 16-bit program counter and issues word reads to instruction memory over a request/grant plus in-order response handshake.
- Buffers returned words in a small prefetch queue and presents one instruction per cycle on q.
- Handles redirects from branch/call/return resolution and the decoder's hold_pc one-cycle hold.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- DEPTH, 2, prefetch queue entries; power of two, 2..8.
- NOP_WORD, 16'h0000, word driven on q when no valid instruction is present.

Ports:
- clk  in  1  clock, rising edge
- rst_s  in  1  synchronous reset, active-high (rst_s=1 resets on the clk edge)
- imem_req  out  1  read request this cycle
- imem_addr  out  16  word address of the request
- imem_gnt  in  1  request accepted this cycle (same-cycle); imem_req/imem_addr need not persist past an ungranted cycle
- imem_rvalid  in  1  read data valid; responses arrive in request order, latency >=1
- imem_rdata  in  16  instruction word
- redirect_val  in  1  flush and restart fetch
- redirect_pc  in  16  restart address
- stall  in  1  downstream cannot accept q this cycle
- hold_pc  in  1  decoder hold request (return/rti)
- q  out  16  instruction to decoder
- q_valid  out  1  q holds a real instruction
- q_pc  out  16  address of the instruction on q

Behaviour:
- Reset values: fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, hold_seen=0, imem_req=0, q=NOP_WORD, q_valid=0, q_pc=0. Reset overrides all inputs, including mid-transaction; responses after reset are not discarded, so memory must also be reset.
- Credit: imem_req = ~rst_s & ~redirect_val & (occupancy + outstanding < DEPTH); imem_addr = fetch_pc.
- On imem_req & imem_gnt: fetch_pc <= fetch_pc+1 (wraps 16'hFFFF->0); outstanding++.
- On imem_rvalid with discard>0 or redirect_val: word dropped.
- On imem_rvalid otherwise: push {pc_of_response, rdata}. pc_of_response comes from a tag register advanced per accepted response (resp_pc).
- Every rvalid decrements outstanding. A simultaneous grant and rvalid leaves outstanding unchanged.
- Queue never overflows by construction (credit rule). A push to an empty queue is visible on q the next cycle (fetch-to-q latency = memory latency + 1).
- q/q_pc are the queue head when non-empty; otherwise q=NOP_WORD, q_valid=0.
- Pop = q_valid & ~stall & ~(hold_pc & ~hold_seen) & ~redirect_val.
- hold_seen <= hold_pc & q_valid & ~hold_seen & ~stall & ~redirect_val. It clears on pop. The first hold_pc cycle therefore freezes q for exactly one cycle and the second cycle pops.
- Simultaneous push and pop on a full queue is legal; occupancy is unchanged.
- Redirect (highest priority, single cycle):
  - queue cleared;
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc;
  - discard <= outstanding - (imem_rvalid ? 1 : 0);
  - hold_seen <= 0;
  - no request issued that cycle.
- Requests resume the next cycle and may overlap discarding, because responses are in order.
- Redirect while already discarding: the same formula applies and is cumulative via outstanding.
- Redirect and stall together: redirect wins.
- FSM (2 states, for q_valid gating only):
  - RUN -> FLUSH on redirect_val when outstanding-after-cycle>0;
  - FLUSH -> RUN when discard reaches 0;
  - no pushes occur in FLUSH.
- Counters are $clog2(DEPTH)+1 bits; outstanding and discard never exceed DEPTH.

Decomposition:
- Shared package/include: NOP encoding, RESET_PC default, fetch FSM state encodings (FS_RUN, FS_FLUSH), reused alongside the existing opcode include.
- One sub-module, fetch_queue: synchronous DEPTH x 32-bit FIFO with push/pop/clear, full/empty, occupancy.
- PC, credit and discard logic stay in fetch_unit.

Test Plan:
- Reset, then memory with 1-cycle latency and always-granted: addresses 0,1,2 requested on consecutive cycles; q shows mem[0] at cycle 3 with q_pc=0; then one instruction per cycle, q_valid held 1.
- stall held 4 cycles with DEPTH=2: at most 2 queued plus 0 outstanding; imem_req drops to 0; q stays constant; resumes in order with no loss or duplicate.
- Redirect to 16'h0040 with 2 outstanding (latency 3): both stale responses dropped; the next q_valid shows mem[0x40] with q_pc=0x40; no stale word ever has q_valid=1.
- hold_pc held 2 cycles while q=return word: q unchanged on cycle 1, popped on cycle 2, next word on cycle 3.
- fetch_pc at 16'hFFFF: next request address is 16'h0000 and q_pc follows the wrap.
- rst_s asserted mid-burst with a grant pending: imem_req=0 and q_valid=0 next cycle; after release, first request is RESET_PC.
